custom_axi_ip_engine: RTL and testbench

Parametrised successor of the single-shot register-driven compute core. It accepts a job through a valid/ready start handshake and iterates a selectable ALU operation a programmable number of times. It returns the result through a valid/ready handshake and reports sticky error codes. It sits behind the AXI-Lite register block: registers drive the job fields, and the result, status and progress are read back.

---
 rtl/custom_axi_ip_pkg.sv | 29 ++
 rtl/custom_axi_ip_alu.sv | 38 +++
 rtl/custom_axi_ip_engine.sv | 138 +++++++++++++
 tb/tb_custom_axi_ip_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the iterating ALU engine: FSM status, ALU op and sticky error codes.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ZERO_ITER = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_ABORT     = 2'd3
    } err_e;

    function automatic err_e err_reset_value();
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/custom_axi_ip_alu.sv
// Combinational ALU: acc op operand with carry/borrow flag; zero latency, no flow control.
// Overflow is bit DATA_WIDTH of the widened add/sub; XOR and PASS never flag it.
module custom_axi_ip_alu
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  ovf
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                y   = sum[DATA_WIDTH-1:0];
                ovf = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                y   = diff[DATA_WIDTH-1:0];
                ovf = diff[DATA_WIDTH];
            end
            OP_XOR:  y = a ^ b;
            OP_PASS: y = b;
        endcase
    end

endmodule

// File: rtl/custom_axi_ip_engine.sv
// Job engine: accepts a job on start handshake, iterates the ALU N times, returns result on valid/ready.
// Latency N+1 cycles from start handshake to result_valid_o; result held until result_ready_i.
module custom_axi_ip_engine
    import custom_axi_ip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [1:0]            op_i,
    input  logic [CNT_W-1:0]      iter_i,
    input  logic                  ovf_err_en_i,
    input  logic                  abort_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [1:0]            status_o,
    output logic [1:0]            err_code_o,
    output logic [CNT_W-1:0]      progress_o
);

    status_e               state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            op_q, op_d;
    logic                  ovf_en_q, ovf_en_d;
    err_e                  err_q, err_d;
    logic [CNT_W-1:0]      prog_q, prog_d;

    logic [DATA_WIDTH-1:0] alu_y;
    logic                  alu_ovf;

    custom_axi_ip_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a   (acc_q),
        .b   (opnd_q),
        .op  (op_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            ovf_en_q <= 1'b0;
            err_q    <= err_reset_value();
            prog_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            op_q     <= op_d;
            ovf_en_q <= ovf_en_d;
            err_q    <= err_d;
            prog_q   <= prog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        op_d     = op_q;
        ovf_en_d = ovf_en_q;
        err_d    = err_q;
        prog_d   = prog_q;

        case (state_q)
            IDLE: begin
                if (start_valid_i) begin
                    acc_d    = data_i;
                    opnd_d   = operand_i;
                    op_d     = op_i;
                    ovf_en_d = ovf_err_en_i;
                    if (iter_i == '0) begin
                        state_d = ERROR;
                        err_d   = ERR_ZERO_ITER;
                        prog_d  = '0;
                    end else begin
                        state_d = BUSY;
                        prog_d  = iter_i;
                    end
                end
            end
            BUSY: begin
                // Abort outranks overflow; both leave acc and progress frozen.
                if (abort_i) begin
                    state_d = ERROR;
                    err_d   = ERR_ABORT;
                end else if (ovf_en_q && alu_ovf) begin
                    state_d = ERROR;
                    err_d   = ERR_OVERFLOW;
                end else begin
                    acc_d  = alu_y;
                    prog_d = prog_q - CNT_W'(1);
                    if (prog_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        result_d = alu_y;
                    end
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (clear_i) begin
                    state_d = IDLE;
                    err_d   = err_reset_value();
                    prog_d  = '0;
                end
            end
        endcase
    end

    assign start_ready_o  = (state_q == IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign status_o       = state_q;
    assign err_code_o     = err_q;
    assign progress_o     = prog_q;

endmodule

// File: tb/tb_custom_axi_ip_engine.sv
// Directed plus randomized job sequences checked against a loop-level reference model.
module tb_custom_axi_ip_engine;
    import custom_axi_ip_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_valid_i;
    logic          start_ready_o;
    logic [DW-1:0] data_i;
    logic [DW-1:0] operand_i;
    logic [1:0]    op_i;
    logic [CW-1:0] iter_i;
    logic          ovf_err_en_i;
    logic          abort_i;
    logic          clear_i;
    logic [DW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic [1:0]    status_o;
    logic [1:0]    err_code_o;
    logic [CW-1:0] progress_o;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] last_result = '0;

    custom_axi_ip_engine #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .data_i         (data_i),
        .operand_i      (operand_i),
        .op_i           (op_i),
        .iter_i         (iter_i),
        .ovf_err_en_i   (ovf_err_en_i),
        .abort_i        (abort_i),
        .clear_i        (clear_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .status_o       (status_o),
        .err_code_o     (err_code_o),
        .progress_o     (progress_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".status"}, status_o, IDLE);
        chk({tag, ".start_ready"}, start_ready_o, 1'b1);
        chk({tag, ".valid"}, result_valid_o, 1'b0);
        chk({tag, ".err"}, err_code_o, ERR_NONE);
        chk({tag, ".progress"}, progress_o, 0);
    endtask

    // Runs one job from the IDLE negedge; abort_at = BUSY cycle in which abort_i is raised (0 = none).
    task automatic run_job(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] opnd,
                           input op_e op, input int n, input bit oe, input int abort_at, input int hold);
        logic [DW-1:0] acc;
        longint        wide;
        bit            carry;
        err_e          e;
        int            stop;
        int            nb;
        acc  = d;
        e    = ERR_NONE;
        stop = 0;
        if (n == 0) e = ERR_ZERO_ITER;
        for (int i = 1; i <= n && e == ERR_NONE; i++) begin
            if (i == abort_at) begin
                e = ERR_ABORT;
                stop = i;
            end else begin
                carry = 1'b0;
                case (op)
                    OP_ADD: begin
                        wide  = longint'(acc) + longint'(opnd);
                        carry = wide > 64'hFFFF_FFFF;
                    end
                    OP_SUB: begin
                        wide  = longint'(acc) - longint'(opnd);
                        carry = opnd > acc;
                    end
                    OP_XOR:  wide = longint'(acc ^ opnd);
                    default: wide = longint'(opnd);
                endcase
                if (oe && carry) begin
                    e = ERR_OVERFLOW;
                    stop = i;
                end else begin
                    acc = wide[DW-1:0];
                end
            end
        end
        nb = (e == ERR_NONE) ? n : stop;

        chk({tag, ".ready_before"}, start_ready_o, 1'b1);
        data_i = d; operand_i = opnd; op_i = op; iter_i = CW'(n); ovf_err_en_i = oe;
        start_valid_i = 1'b1;
        @(negedge clk_i);
        start_valid_i = 1'b0;
        data_i = $urandom; operand_i = $urandom; op_i = 2'($urandom);
        iter_i = CW'($urandom); ovf_err_en_i = 1'($urandom);
        for (int k = 1; k <= nb; k++) begin
            chk({tag, ".busy"}, status_o, BUSY);
            chk({tag, ".progress"}, progress_o, n - k + 1);
            chk({tag, ".valid_busy"}, result_valid_o, 1'b0);
            abort_i = (k == abort_at);
            @(negedge clk_i);
            abort_i = 1'b0;
        end

        if (e == ERR_NONE) begin
            last_result = acc;
            abort_i = 1'b1;
            clear_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                chk({tag, ".done"}, status_o, DONE);
                chk({tag, ".result"}, result_o, acc);
                chk({tag, ".valid"}, result_valid_o, 1'b1);
                chk({tag, ".ready_done"}, start_ready_o, 1'b0);
                @(negedge clk_i);
            end
            abort_i = 1'b0;
            clear_i = 1'b0;
            chk({tag, ".done"}, status_o, DONE);
            chk({tag, ".result"}, result_o, acc);
            chk({tag, ".valid"}, result_valid_o, 1'b1);
            result_ready_i = 1'b1;
            @(negedge clk_i);
            result_ready_i = 1'b0;
            chk_idle({tag, ".after_done"});
        end else begin
            start_valid_i = 1'b1;
            abort_i = 1'b1;
            for (int h = 0; h < 2; h++) begin
                chk({tag, ".error"}, status_o, ERROR);
                chk({tag, ".err_code"}, err_code_o, e);
                chk({tag, ".progress_err"}, progress_o, (n == 0) ? 0 : n - stop + 1);
                chk({tag, ".valid_err"}, result_valid_o, 1'b0);
                chk({tag, ".result_err"}, result_o, last_result);
                @(negedge clk_i);
            end
            start_valid_i = 1'b0;
            abort_i = 1'b0;
            clear_i = 1'b1;
            @(negedge clk_i);
            clear_i = 1'b0;
            chk_idle({tag, ".after_clear"});
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start_valid_i = 1'b0; data_i = '0; operand_i = '0; op_i = '0; iter_i = '0;
        ovf_err_en_i = 1'b0; abort_i = 1'b0; clear_i = 1'b0; result_ready_i = 1'b0;

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_idle("reset");
        chk("reset.result", result_o, 0);

        run_job("add", 32'h10, 32'h3, OP_ADD, 4, 1'b0, 0, 5);
        @(negedge clk_i);
        run_job("sub_wrap", 32'h1, 32'h2, OP_SUB, 1, 1'b0, 0, 0);
        @(negedge clk_i);
        run_job("sub_ovf", 32'h1, 32'h2, OP_SUB, 1, 1'b1, 0, 0);
        @(negedge clk_i);
        run_job("zero_iter", 32'h55, 32'h7, OP_XOR, 0, 1'b0, 0, 0);
        @(negedge clk_i);
        run_job("abort_vs_ovf", 32'hFFFF_FFFD, 32'h1, OP_ADD, 10, 1'b1, 3, 0);

        abort_i = 1'b1;
        repeat (2) @(negedge clk_i);
        abort_i = 1'b0;
        chk_idle("idle_abort");

        run_job("xor", 32'hA5A5_A5A5, 32'hFFFF_FFFF, OP_XOR, 3, 1'b0, 0, 1);
        @(negedge clk_i);
        run_job("pass", 32'hFFFF_FFFF, 32'h1234_5678, OP_PASS, 2, 1'b1, 0, 2);
        @(negedge clk_i);

        for (int r = 0; r < 12; r++) begin
            int n;
            int ab;
            n  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
            run_job("rand", $urandom, $urandom, op_e'($urandom_range(0, 3)), n,
                    1'($urandom), ab, $urandom_range(0, 3));
            @(negedge clk_i);
        end

        // Asynchronous reset in the middle of a job, checked before any clock edge.
        data_i = 32'h10; operand_i = 32'h3; op_i = OP_ADD; iter_i = 8'd6;
        start_valid_i = 1'b1;
        @(negedge clk_i);
        start_valid_i = 1'b0;
        @(negedge clk_i);
        chk("midrst.busy", status_o, BUSY);
        #2 rst_ni = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst.result", result_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
